// File: rtl/zeroheti_obi_apb_bridge.sv
// OBI subordinate to multi-port APB4 manager bridge.
//
// Accepts one OBI transaction at a time and forwards it to one of NumApbSbr APB4 subordinates.
// The subordinate is picked by a built-in address decoder over a contiguous window of
// NumApbSbr * SbrSpan bytes starting at BaseAddr. An access outside the window gets an error
// response and never touches the APB side. An access that waits more than TimeoutCycles
// ACCESS cycles is aborted with an error. TimeoutCycles = 0 disables the timeout.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   obi_req_i/gnt_o    OBI request handshake (gnt only while idle)
//   obi_addr_i/we_i/be_i/wdata_i   OBI request payload
//   obi_rvalid_o/rdata_o/err_o     OBI response, rvalid is a single-cycle pulse
//   paddr_o, psel_o (one-hot), penable_o, pwrite_o, pstrb_o, pwdata_o   APB4 request
//   prdata_i, pready_i, pslverr_i  per-subordinate APB4 response; unselected ones are ignored
module zeroheti_obi_apb_bridge #(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          NumApbSbr     = 4,
    parameter logic [AddrWidth-1:0] BaseAddr      = 32'h0003_0000,
    parameter logic [AddrWidth-1:0] SbrSpan       = 32'h0000_0100,
    parameter int unsigned          TimeoutCycles = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    // OBI subordinate port
    input  logic                       obi_req_i,
    output logic                       obi_gnt_o,
    input  logic [AddrWidth-1:0]       obi_addr_i,
    input  logic                       obi_we_i,
    input  logic [3:0]                 obi_be_i,
    input  logic [31:0]                obi_wdata_i,
    output logic                       obi_rvalid_o,
    output logic [31:0]                obi_rdata_o,
    output logic                       obi_err_o,
    // APB4 manager port
    output logic [AddrWidth-1:0]       paddr_o,
    output logic [NumApbSbr-1:0]       psel_o,
    output logic                       penable_o,
    output logic                       pwrite_o,
    output logic [3:0]                 pstrb_o,
    output logic [31:0]                pwdata_o,
    input  logic [NumApbSbr-1:0][31:0] prdata_i,
    input  logic [NumApbSbr-1:0]       pready_i,
    input  logic [NumApbSbr-1:0]       pslverr_i
);

    localparam int unsigned IdxW     = (NumApbSbr > 1) ? $clog2(NumApbSbr) : 1;
    localparam int unsigned SpanLog2 = $clog2(SbrSpan);
    localparam int unsigned CntW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    // Window bounds carry one extra bit so a window ending at the top of the address space
    // does not wrap.
    localparam logic [AddrWidth:0] WinLo = {1'b0, BaseAddr};
    localparam logic [AddrWidth:0] WinHi = WinLo + (AddrWidth + 1)'(NumApbSbr) * {1'b0, SbrSpan};
    localparam logic [CntW-1:0]    CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   req_hit;
    logic [IdxW-1:0]        req_idx;
    logic [AddrWidth:0]     addr_ext;

    assign addr_ext = {1'b0, obi_addr_i};
    assign req_hit  = (addr_ext >= WinLo) && (addr_ext < WinHi);
    assign req_idx  = IdxW'((obi_addr_i - BaseAddr) >> SpanLog2);

    assign obi_gnt_o = obi_req_i && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (obi_gnt_o) begin
                    if (req_hit) begin
                        // Request fields are only captured on a hit so that a decode miss
                        // leaves every APB output untouched.
                        addr_d  = obi_addr_i;
                        we_d    = obi_we_i;
                        be_d    = obi_be_i;
                        wdata_d = obi_wdata_i;
                        idx_d   = req_idx;
                        state_d = StSetup;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (pready_i[idx_q]) begin
                    rdata_d = we_q ? 32'h0 : prdata_i[idx_q];
                    err_d   = pslverr_i[idx_q];
                    state_d = StResp;
                end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                // Response registers clear so the OBI outputs read 0 outside the rvalid pulse.
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        psel_o = '0;
        if ((state_q == StSetup) || (state_q == StAccess)) begin
            psel_o[idx_q] = 1'b1;
        end
    end

    assign penable_o    = (state_q == StAccess);
    assign paddr_o      = addr_q;
    assign pwrite_o     = we_q;
    assign pstrb_o      = we_q ? be_q : 4'h0;
    assign pwdata_o     = wdata_q;

    assign obi_rvalid_o = (state_q == StResp);
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
module tb_zeroheti_obi_apb_bridge;

    localparam logic [31:0] Base = 32'h0003_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             obi_req;
    logic             obi_gnt;
    logic [31:0]      obi_addr;
    logic             obi_we;
    logic [3:0]       obi_be;
    logic [31:0]      obi_wdata;
    logic             obi_rvalid;
    logic [31:0]      obi_rdata;
    logic             obi_err;
    logic [31:0]      paddr;
    logic [3:0]       psel;
    logic             penable;
    logic             pwrite;
    logic [3:0]       pstrb;
    logic [31:0]      pwdata;
    logic [3:0][31:0] prdata;
    logic [3:0]       pready;
    logic [3:0]       pslverr;

    always #5 clk = ~clk;

    zeroheti_obi_apb_bridge #(
        .AddrWidth    (32),
        .NumApbSbr    (4),
        .BaseAddr     (Base),
        .SbrSpan      (32'h0000_0100),
        .TimeoutCycles(4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .obi_req_i   (obi_req),
        .obi_gnt_o   (obi_gnt),
        .obi_addr_i  (obi_addr),
        .obi_we_i    (obi_we),
        .obi_be_i    (obi_be),
        .obi_wdata_i (obi_wdata),
        .obi_rvalid_o(obi_rvalid),
        .obi_rdata_o (obi_rdata),
        .obi_err_o   (obi_err),
        .paddr_o     (paddr),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pstrb_o     (pstrb),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;   // ACCESS cycles before pready, -1 = never
        logic [3:0]  slverr;
        logic [3:0]  psel;    // expected select, 0 = decode miss
        logic [31:0] rdata;
        logic        err;
        int          lat;     // cycles from gnt to rvalid
    } vec_t;

    typedef struct {
        vec_t v;
        int   gnt_cyc;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_wait = 0;
    int acc_cnt = 0;
    logic [3:0] cur_slverr = 4'h0;

    logic [3:0]  psel_or;
    logic [31:0] cap_paddr, cap_pwdata;
    logic        cap_pwrite;
    logic [3:0]  cap_pstrb;

    assign pslverr = cur_slverr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // APB subordinate model: every subordinate answers pready after cur_wait ACCESS cycles.
    always @(negedge clk) begin
        if (penable) begin
            pready  <= (cur_wait >= 0 && acc_cnt == cur_wait) ? 4'hF : 4'h0;
            acc_cnt <= acc_cnt + 1;
        end else begin
            pready  <= 4'h0;
            acc_cnt <= 0;
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            psel_or = 4'h0;
        end else begin
            if (obi_gnt) chk("gnt_only_idle", {29'h0, obi_rvalid, |psel, penable}, 32'h0);
            if (psel != 4'h0) begin
                chk("psel_onehot", {31'h0, $onehot(psel)}, 32'h1);
                psel_or    = psel_or | psel;
                cap_paddr  = paddr;
                cap_pwrite = pwrite;
                cap_pstrb  = pstrb;
                cap_pwdata = pwdata;
            end
            if (obi_rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {31'h0, obi_rvalid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk({e.v.name, "_rdata"}, obi_rdata, e.v.rdata);
                    chk({e.v.name, "_err"}, {31'h0, obi_err}, {31'h0, e.v.err});
                    chk({e.v.name, "_latency"}, cyc - e.gnt_cyc, e.v.lat);
                    chk({e.v.name, "_psel_seen"}, {28'h0, psel_or}, {28'h0, e.v.psel});
                    chk({e.v.name, "_apb_idle_in_resp"}, {27'h0, psel, penable}, 32'h0);
                    if (e.v.psel != 4'h0) begin
                        chk({e.v.name, "_paddr"}, cap_paddr, e.v.addr);
                        chk({e.v.name, "_pwrite"}, {31'h0, cap_pwrite}, {31'h0, e.v.we});
                        chk({e.v.name, "_pstrb"}, {28'h0, cap_pstrb},
                            e.v.we ? {28'h0, e.v.be} : 32'h0);
                        if (e.v.we) chk({e.v.name, "_pwdata"}, cap_pwdata, e.v.wdata);
                    end
                end
                psel_or = 4'h0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the grant.
    task automatic issue(input vec_t v, input bit keep_req);
        int n;
        exp_t e;
        cur_wait   = v.waits;
        cur_slverr = v.slverr;
        obi_req    = 1'b1;
        obi_addr   = v.addr;
        obi_we     = v.we;
        obi_be     = v.be;
        obi_wdata  = v.wdata;
        #1;
        n = 0;
        while (!obi_gnt && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!obi_gnt) begin
            chk({v.name, "_gnt_timeout"}, {31'h0, obi_gnt}, 32'h1);
            obi_req = 1'b0;
            return;
        end
        e.v       = v;
        e.gnt_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        if (!keep_req) obi_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", sb.size(), 32'h0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 4; k++) prdata[k] = 32'hCAFE_0000 + k;
        pready = 4'h0;
        //                name           addr          we    be     wdata          wt  slverr psel     rdata          err  lat
        vecs[0] = '{"rd_sbr1",        Base + 32'h104, 1'b0, 4'hF, 32'h0,         0,  4'h0, 4'b0010, 32'hCAFE_0001, 1'b0, 3};
        vecs[1] = '{"wr_sbr3_2ws",    Base + 32'h300, 1'b1, 4'h5, 32'h1234_5678, 2,  4'h0, 4'b1000, 32'h0,         1'b0, 5};
        vecs[2] = '{"rd_miss_above",  Base + 32'h400, 1'b0, 4'hF, 32'h0,         0,  4'h0, 4'b0000, 32'h0,         1'b1, 1};
        vecs[3] = '{"rd_timeout",     Base,           1'b0, 4'hF, 32'h0,         -1, 4'h0, 4'b0001, 32'h0,         1'b1, 6};
        vecs[4] = '{"rd_ready_last",  Base,           1'b0, 4'hF, 32'h0,         3,  4'h0, 4'b0001, 32'hCAFE_0000, 1'b0, 6};
        vecs[5] = '{"rd_slverr_sbr2", Base + 32'h200, 1'b0, 4'hF, 32'h0,         0,  4'h5, 4'b0100, 32'hCAFE_0002, 1'b1, 3};
        vecs[6] = '{"rd_unsel_err",   Base + 32'h302, 1'b0, 4'hF, 32'h0,         0,  4'h1, 4'b1000, 32'hCAFE_0003, 1'b0, 3};
        vecs[7] = '{"rd_miss_below",  Base - 32'h4,   1'b0, 4'hF, 32'h0,         0,  4'h0, 4'b0000, 32'h0,         1'b1, 1};
        vecs[8] = '{"rd_last_slverr", Base,           1'b0, 4'hF, 32'h0,         3,  4'h1, 4'b0001, 32'hCAFE_0000, 1'b1, 6};
        vecs[9] = '{"wr_sbr2_slverr", Base + 32'h280, 1'b1, 4'hC, 32'hA5A5_5A5A, 1,  4'h4, 4'b0100, 32'h0,         1'b1, 4};

        rst_n     = 1'b0;
        obi_req   = 1'b0;
        obi_addr  = '0;
        obi_we    = 1'b0;
        obi_be    = '0;
        obi_wdata = '0;
        #2;
        chk("reset_psel", {28'h0, psel}, 32'h0);
        chk("reset_penable", {31'h0, penable}, 32'h0);
        chk("reset_rvalid", {31'h0, obi_rvalid}, 32'h0);
        chk("reset_paddr", paddr, 32'h0);
        chk("reset_pstrb", {28'h0, pstrb}, 32'h0);
        chk("reset_rdata_err", {obi_rdata[30:0], obi_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i], 1'b0);
            wait_idle();
        end

        // Reset during ACCESS: outputs drop at once, the access never responds.
        cur_wait   = -1;
        cur_slverr = 4'h0;
        obi_req    = 1'b1;
        obi_addr   = Base + 32'h100;
        obi_we     = 1'b0;
        #1;
        n = 0;
        while (!obi_gnt && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        obi_req = 1'b0;
        n = 0;
        while (!penable && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_test_reached_access", {31'h0, penable}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", {28'h0, psel}, 32'h0);
        chk("rst_mid_penable", {31'h0, penable}, 32'h0);
        chk("rst_mid_rvalid", {31'h0, obi_rvalid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(vecs[0], 1'b0);
        wait_idle();

        // Back-to-back with req held high.
        issue(vecs[0], 1'b1);
        issue(vecs[2], 1'b1);
        issue(vecs[6], 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
